// File: rtl/imem_loadable_if.sv
// Fetch and program-load signal bundle for imem_loadable.
// master drives requests and load data; slave is the memory.
interface imem_loadable_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 8
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [N-1:0]      rd_data;
  logic              rd_valid;

  logic              ld_start;
  logic [ADDR_W:0]   ld_count;
  logic              ld_valid;
  logic              ld_ready;
  logic [N-1:0]      ld_data;
  logic              ld_busy;
  logic              ld_done;

  modport master (
    output rd_en, rd_addr, ld_start, ld_count, ld_valid, ld_data,
    input  rd_data, rd_valid, ld_ready, ld_busy, ld_done
  );

  modport slave (
    input  rd_en, rd_addr, ld_start, ld_count, ld_valid, ld_data,
    output rd_data, rd_valid, ld_ready, ld_busy, ld_done
  );

endinterface

// File: rtl/imem_loadable.sv
// Instruction memory with a registered 1-cycle fetch port and a valid/ready
// program-load port; optional zero-fill sweep after reset.
module imem_loadable #(
  parameter int unsigned N              = 32,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic            clk,
  input logic            reset,
  imem_loadable_if.slave bus
);

  typedef enum logic [1:0] {
    StClear,
    StRun,
    StLoad
  } state_e;

  localparam logic [ADDR_W:0]   DepthCnt   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(DEPTH - 1);
  localparam state_e            ResetState = (CLEAR_ON_RESET != 0) ? StClear : StRun;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [N-1:0]      rd_data_q;
  logic              rd_valid_q;
  logic              ld_done_q;

  logic [N-1:0]      mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [N-1:0]      mem_wdata;
  logic [ADDR_W:0]   ld_cnt_clamped;

  assign ld_cnt_clamped = (bus.ld_count > DepthCnt) ? DepthCnt : bus.ld_count;

  // Single write port shared by the zero-fill sweep and the loader; reset aborts both.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == StClear) begin
        mem_we = 1'b1;
      end else if (state_q == StLoad && bus.ld_valid) begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr_q[ADDR_W-1:0];
        mem_wdata = bus.ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ResetState;
      clr_ptr_q  <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      ld_done_q  <= 1'b0;
      unique case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LastAddr) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (bus.rd_en) begin
            rd_data_q  <= mem[bus.rd_addr];
            rd_valid_q <= 1'b1;
          end
          if (bus.ld_start) begin
            cnt_q    <= ld_cnt_clamped;
            wr_ptr_q <= '0;
            if (ld_cnt_clamped == '0) begin
              ld_done_q <= 1'b1;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (bus.ld_valid) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wr_ptr_q == cnt_q - 1'b1) begin
              state_q   <= StRun;
              ld_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ld_done  = ld_done_q;
  // Decoded from state, but forced to reset values while reset is held.
  assign bus.ld_ready = !reset && (state_q == StLoad);
  assign bus.ld_busy  = reset || (state_q != StRun);

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: two instances (zero-fill on and off) share one stimulus
// stream and are checked every cycle against a word-level model.
module tb_imem_loadable;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int MClear = 0;
  localparam int MRun   = 1;
  localparam int MLoad  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          ld_start;
  logic [AW:0]   ld_count;
  logic          ld_valid;
  logic [N-1:0]  ld_data;

  always #5 clk = ~clk;

  imem_loadable_if #(.N(N), .ADDR_W(AW)) ifa ();
  imem_loadable_if #(.N(N), .ADDR_W(AW)) ifb ();

  assign ifa.rd_en    = rd_en;
  assign ifa.rd_addr  = rd_addr;
  assign ifa.ld_start = ld_start;
  assign ifa.ld_count = ld_count;
  assign ifa.ld_valid = ld_valid;
  assign ifa.ld_data  = ld_data;
  assign ifb.rd_en    = rd_en;
  assign ifb.rd_addr  = rd_addr;
  assign ifb.ld_start = ld_start;
  assign ifb.ld_count = ld_count;
  assign ifb.ld_valid = ld_valid;
  assign ifb.ld_data  = ld_data;

  imem_loadable #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_ON_RESET(1)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa)
  );

  imem_loadable #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_ON_RESET(0)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ifb)
  );

  logic [N-1:0] o_data [2];
  logic         o_valid[2];
  logic         o_ready[2];
  logic         o_busy [2];
  logic         o_done [2];

  assign o_data[0]  = ifa.rd_data;
  assign o_valid[0] = ifa.rd_valid;
  assign o_ready[0] = ifa.ld_ready;
  assign o_busy[0]  = ifa.ld_busy;
  assign o_done[0]  = ifa.ld_done;
  assign o_data[1]  = ifb.rd_data;
  assign o_valid[1] = ifb.rd_valid;
  assign o_ready[1] = ifb.ld_ready;
  assign o_busy[1]  = ifb.ld_busy;
  assign o_done[1]  = ifb.ld_done;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, inst, $time, got, exp);
    end
  endtask

  // Word-level model: a mode per instance, countdowns, and a memory image with
  // a per-word "known" flag (instance 1 starts with undefined contents).
  int           m_mode     [2];
  int           m_clr_left [2];
  int           m_left     [2];
  int           m_addr     [2];
  logic [N-1:0] m_mem      [2][DEPTH];
  bit           m_known    [2][DEPTH];
  logic [N-1:0] e_data     [2];
  bit           e_known    [2];
  bit           e_valid    [2];
  bit           e_done     [2];
  bit           m_active = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i]     = (i == 0) ? MClear : MRun;
        m_clr_left[i] = DEPTH;
        e_data[i]     = '0;
        e_known[i]    = 1'b1;
        e_valid[i]    = 1'b0;
        e_done[i]     = 1'b0;
      end else begin
        e_valid[i] = 1'b0;
        e_done[i]  = 1'b0;
        if (m_mode[i] == MClear) begin
          m_clr_left[i]--;
          if (m_clr_left[i] == 0) begin
            for (int j = 0; j < DEPTH; j++) begin
              m_mem[i][j]   = '0;
              m_known[i][j] = 1'b1;
            end
            m_mode[i] = MRun;
          end
        end else if (m_mode[i] == MRun) begin
          if (rd_en) begin
            e_data[i]  = m_mem[i][rd_addr];
            e_known[i] = m_known[i][rd_addr];
            e_valid[i] = 1'b1;
          end
          if (ld_start) begin
            int c;
            c = (int'(ld_count) > DEPTH) ? DEPTH : int'(ld_count);
            if (c == 0) begin
              e_done[i] = 1'b1;
            end else begin
              m_mode[i] = MLoad;
              m_left[i] = c;
              m_addr[i] = 0;
            end
          end
        end else begin
          if (ld_valid) begin
            m_mem[i][m_addr[i]]   = ld_data;
            m_known[i][m_addr[i]] = 1'b1;
            m_addr[i]++;
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_mode[i] = MRun;
              e_done[i] = 1'b1;
            end
          end
        end
      end
    end
    if (reset) m_active = 1'b1;
  end

  always @(negedge clk) begin
    if (m_active) begin
      for (int i = 0; i < 2; i++) begin
        check("ld_busy", i, 32'(o_busy[i]), 32'(reset || m_mode[i] != MRun));
        check("ld_ready", i, 32'(o_ready[i]), 32'(!reset && m_mode[i] == MLoad));
        check("ld_done", i, 32'(o_done[i]), 32'(e_done[i]));
        check("rd_valid", i, 32'(o_valid[i]), 32'(e_valid[i]));
        if (e_known[i]) check("rd_data", i, o_data[i], e_data[i]);
      end
    end
  end

  int done_cnt[2] = '{0, 0};
  int acc     [2] = '{0, 0};
  bit ready_seen = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (o_done[i]) done_cnt[i]++;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) if (ld_valid && o_ready[i]) acc[i]++;
    if (o_ready[0]) ready_seen = 1'b1;
  end

  logic [31:0] prog[8] = '{32'hd29fffe1, 32'hf8000001, 32'hd2955541, 32'hf8008001,
                           32'hf8400002, 32'h8b020043, 32'hf8010003, 32'hb400001f};

  function automatic logic [31:0] word(input int kind, input int k);
    if (kind == 0 && k < 8) return prog[k];
    if (kind == 2) return 32'h5a5a0000 | 32'(k);
    return 32'ha5000000 | 32'(k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input int a, input logic [31:0] ea, input bit cb,
                        input logic [31:0] eb);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
    check("lit_rd_valid", 0, 32'(o_valid[0]), 32'd1);
    check("lit_rd_data", 0, o_data[0], ea);
    if (cb) begin
      check("lit_rd_valid", 1, 32'(o_valid[1]), 32'd1);
      check("lit_rd_data", 1, o_data[1], eb);
    end
  endtask

  // Returns the number of cycles spent in LOAD until ld_done is seen.
  task automatic do_load(input int count, input int kind, input int vpat, output int cycles);
    int base;
    ld_valid = 1'b0;
    ld_start = 1'b1;
    ld_count = (AW + 1)'(count);
    tick();
    ld_start = 1'b0;
    base     = acc[0];
    cycles   = 0;
    while (!o_done[0] && cycles < 2000) begin
      ld_data  = word(kind, acc[0] - base);
      ld_valid = (vpat == 0) ? 1'b1 : (cycles % 3 == 0);
      tick();
      cycles++;
    end
    ld_valid = 1'b0;
    if (cycles >= 2000) check("load_timeout", 0, 32'(cycles), 32'd0);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((o_busy[0] || o_busy[1]) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check(nm, 0, 32'(n), 32'd0);
  endtask

  initial begin
    int cnt;
    int cyc;
    int d0;
    int d1;
    int a0;

    reset    = 1'b1;
    rd_en    = 1'b0;
    rd_addr  = '0;
    ld_start = 1'b0;
    ld_count = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Zero-fill length, with random fetches that must be ignored by instance 0.
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!o_busy[0]) break;
      cnt++;
      rd_en   = 1'($urandom);
      rd_addr = AW'($urandom);
    end
    rd_en = 1'b0;
    check("lit_clear_len", 0, 32'(cnt), 32'd256);
    rd_chk(0, 32'h0, 1'b0, '0);
    rd_chk(7, 32'h0, 1'b0, '0);
    rd_chk(255, 32'h0, 1'b0, '0);

    // 8-word load, valid held high.
    d0 = done_cnt[0];
    a0 = acc[0];
    do_load(8, 0, 0, cyc);
    check("lit_load8_cycles", 0, 32'(cyc), 32'd8);
    repeat (2) tick();
    check("lit_load8_done_cnt", 0, 32'(done_cnt[0] - d0), 32'd1);
    check("lit_load8_acc", 0, 32'(acc[0] - a0), 32'd8);
    rd_chk(5, 32'h8b020043, 1'b1, 32'h8b020043);
    rd_chk(8, 32'h0, 1'b0, '0);

    // Zero-length load: immediate done, never ready.
    ready_seen = 1'b0;
    d0 = done_cnt[0];
    a0 = acc[0];
    do_load(0, 0, 0, cyc);
    check("lit_load0_cycles", 0, 32'(cyc), 32'd0);
    tick();
    check("lit_load0_done_cnt", 0, 32'(done_cnt[0] - d0), 32'd1);
    check("lit_load0_ready", 0, 32'(ready_seen), 32'd0);
    check("lit_load0_acc", 0, 32'(acc[0] - a0), 32'd0);

    // Oversized count clamps to the full depth.
    a0 = acc[0];
    do_load(300, 1, 0, cyc);
    check("lit_load300_cycles", 0, 32'(cyc), 32'd256);
    tick();
    check("lit_load300_acc", 0, 32'(acc[0] - a0), 32'd256);

    // 8-word load with ld_valid pattern 1,0,0 repeating.
    d0 = done_cnt[0];
    do_load(8, 0, 1, cyc);
    check("lit_toggle_cycles", 0, 32'(cyc), 32'd22);
    repeat (3) tick();
    check("lit_toggle_done_cnt", 0, 32'(done_cnt[0] - d0), 32'd1);
    rd_chk(5, 32'h8b020043, 1'b1, 32'h8b020043);
    rd_chk(8, 32'ha5000008, 1'b1, 32'ha5000008);

    // Fetch together with ld_start is served; fetch during LOAD is not.
    rd_en    = 1'b1;
    rd_addr  = AW'(5);
    ld_start = 1'b1;
    ld_count = (AW + 1)'(2);
    tick();
    ld_start = 1'b0;
    check("lit_start_rd_valid", 0, 32'(o_valid[0]), 32'd1);
    check("lit_start_rd_data", 0, o_data[0], 32'h8b020043);
    check("lit_start_ready", 0, 32'(o_ready[0]), 32'd1);
    ld_valid = 1'b1;
    ld_data  = prog[0];
    tick();
    check("lit_load_rd_valid", 0, 32'(o_valid[0]), 32'd0);
    ld_data = prog[1];
    tick();
    check("lit_start_done", 0, 32'(o_done[0]), 32'd1);
    ld_valid = 1'b0;
    rd_en    = 1'b0;
    tick();

    // Reset after three words of an eight-word load.
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    ld_start = 1'b1;
    ld_count = (AW + 1)'(8);
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_data = word(2, k);
      tick();
    end
    ld_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    wait_idle("abort_clear_timeout");
    tick();
    check("lit_abort_done_cnt", 0, 32'(done_cnt[0] - d0), 32'd0);
    check("lit_abort_done_cnt", 1, 32'(done_cnt[1] - d1), 32'd0);
    rd_chk(0, 32'h0, 1'b1, 32'h5a5a0000);
    rd_chk(1, 32'h0, 1'b1, 32'h5a5a0001);
    rd_chk(2, 32'h0, 1'b1, 32'h5a5a0002);
    rd_chk(3, 32'h0, 1'b1, 32'hf8008001);

    // Randomised traffic including occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rd_en    = 1'($urandom);
      rd_addr  = AW'($urandom);
      ld_start = ($urandom % 8 == 0);
      ld_count = ($urandom % 16 == 0) ? (AW + 1)'($urandom_range(250, 300))
                                      : (AW + 1)'($urandom_range(0, 12));
      ld_valid = 1'($urandom);
      ld_data  = $urandom;
      reset    = ($urandom % 900 == 0);
      tick();
    end
    reset    = 1'b0;
    rd_en    = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b1;
    wait_idle("final_idle_timeout");
    ld_valid = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
